// File: rtl/fp_pair_adder.sv
// Sequential IEEE754 single-precision adder for a two-word A/B input burst; fixed 8-cycle latency A->done.
// Build option: define FP_ADD_ROUND_NEAREST_EN for round-to-nearest-even (default: round toward zero).
module fp_pair_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        busy,
    output logic [31:0] res,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPB, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [7:0]         exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [23:0]        man_a_q, man_a_d, man_b_q, man_b_d;
    logic               spec_q, spec_d, zero_q, zero_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic [27:0]        mant_q, mant_d, mb_q, mb_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [31:0]        result_q, result_d, res_q, res_d;
    logic               done_q, done_d;

    // Scratch values for the per-state datapath
    logic [30:0]        mag_a, mag_b;
    logic [31:0]        big_w, sml_w;
    logic               nan_a, nan_b, inf_a, inf_b;
    logic [7:0]         diff;
    logic [27:0]        full_b;
    logic [4:0]         lz;
    logic               inc;
    logic [24:0]        rnd;
    logic [23:0]        m24;
    logic signed [9:0]  e_r;
    logic [31:0]        packed_w;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        exp_a_d    = exp_a_q;
        exp_b_d    = exp_b_q;
        man_a_d    = man_a_q;
        man_b_d    = man_b_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        zero_d     = zero_q;
        mant_d     = mant_q;
        mb_d       = mb_q;
        exp_d      = exp_q;
        result_d   = result_q;
        res_d      = res_q;
        done_d     = 1'b0;

        mag_a    = (a_q[30:23] == 8'd0) ? 31'd0 : a_q[30:0];
        mag_b    = (b_q[30:23] == 8'd0) ? 31'd0 : b_q[30:0];
        big_w    = (mag_b > mag_a) ? {b_q[31], mag_b} : {a_q[31], mag_a};
        sml_w    = (mag_b > mag_a) ? {a_q[31], mag_a} : {b_q[31], mag_b};
        nan_a    = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        nan_b    = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        inf_a    = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        inf_b    = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        diff     = exp_a_q - exp_b_q;
        full_b   = {1'b0, man_b_q, 3'b000};

        // Leading-zero count over hidden..sticky; highest set bit wins
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (mant_q[i]) lz = 5'(26 - i);
        end

`ifdef FP_ADD_ROUND_NEAREST_EN
        inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`else
        inc = 1'b0;
`endif
        rnd = {1'b0, mant_q[26:3]} + {24'd0, inc};
        if (rnd[24]) begin
            m24 = rnd[24:1];
            e_r = exp_q + 10'sd1;
        end else begin
            m24 = rnd[23:0];
            e_r = exp_q;
        end
        if (zero_q) begin
            packed_w = 32'h0000_0000;
        end else if (e_r >= 10'sd255) begin
`ifdef FP_ADD_ROUND_NEAREST_EN
            packed_w = {sign_a_q, 8'hFF, 23'd0};
`else
            packed_w = {sign_a_q, 8'hFE, 23'h7FFFFF};
`endif
        end else if (e_r <= 10'sd0) begin
            packed_w = {sign_a_q, 31'd0};
        end else begin
            packed_w = {sign_a_q, e_r[7:0], m24[22:0]};
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && !done_q) begin
                    a_d     = in_data;
                    state_d = S_CAPB;
                end
            end
            S_CAPB: begin
                if (in_valid) begin
                    b_d     = in_data;
                    state_d = S_UNPACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UNPACK: begin
                sign_a_d = big_w[31];
                exp_a_d  = big_w[30:23];
                man_a_d  = (big_w[30:23] == 8'd0) ? 24'd0 : {1'b1, big_w[22:0]};
                sign_b_d = sml_w[31];
                exp_b_d  = sml_w[30:23];
                man_b_d  = (sml_w[30:23] == 8'd0) ? 24'd0 : {1'b1, sml_w[22:0]};
                spec_d     = 1'b1;
                spec_res_d = 32'h0000_0000;
                if (nan_a || nan_b || (inf_a && inf_b && (a_q[31] != b_q[31])))
                    spec_res_d = 32'h7FC0_0000;
                else if (inf_a)
                    spec_res_d = a_q;
                else if (inf_b)
                    spec_res_d = b_q;
                else if (mag_a == 31'd0 && mag_b == 31'd0)
                    spec_res_d = {a_q[31] & b_q[31], 31'd0};
                else
                    spec_d = 1'b0;
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                mant_d = {1'b0, man_a_q, 3'b000};
                if (diff >= 8'd26)
                    mb_d = {27'd0, |man_b_q};
                else
                    mb_d = (full_b >> diff) | {27'd0, |(full_b & ((28'd1 << diff) - 28'd1))};
                state_d = S_ADD;
            end
            S_ADD: begin
                mant_d  = (sign_a_q == sign_b_q) ? (mant_q + mb_q) : (mant_q - mb_q);
                exp_d   = {2'b00, exp_a_q};
                zero_d  = 1'b0;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (mant_q[27]) begin
                    mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 10'sd1;
                end else if (mant_q == 28'd0) begin
                    zero_d = 1'b1;
                end else begin
                    mant_d = mant_q << lz;
                    exp_d  = exp_q - $signed({5'd0, lz});
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                result_d = spec_q ? spec_res_q : packed_w;
                state_d  = S_DONE;
            end
            S_DONE: begin
                res_d   = result_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            exp_a_q    <= '0;
            exp_b_q    <= '0;
            man_a_q    <= '0;
            man_b_q    <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            zero_q     <= 1'b0;
            mant_q     <= '0;
            mb_q       <= '0;
            exp_q      <= '0;
            result_q   <= '0;
            res_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            exp_a_q    <= exp_a_d;
            exp_b_q    <= exp_b_d;
            man_a_q    <= man_a_d;
            man_b_q    <= man_b_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            zero_q     <= zero_d;
            mant_q     <= mant_d;
            mb_q       <= mb_d;
            exp_q      <= exp_d;
            result_q   <= result_d;
            res_q      <= res_d;
            done_q     <= done_d;
        end
    end

    // In CAPB, busy only asserts once B is actually arriving; a lone A never raises it
    always_comb begin
        busy = done_q
            || ((state_q != S_IDLE) && (state_q != S_CAPB))
            || ((state_q == S_CAPB) && in_valid);
    end

    assign res  = res_q;
    assign done = done_q;

endmodule

// File: tb/tb_fp_pair_adder.sv
// Scoreboard bench for fp_pair_adder: directed operand pairs with hand-computed sums.
module tb_fp_pair_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        busy;
    logic [31:0] res;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];
    int          st_q[$];

    fp_pair_adder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .res      (res),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [31:0] e;
            int s;
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done res=%h at cycle %0d", res, cyc);
            end else begin
                e = exp_q.pop_front();
                s = st_q.pop_front();
                if (res !== e) begin
                    failures++;
                    $display("FAIL sum got=%h want=%h", res, e);
                end
                checks++;
                if (cyc - s != 8) begin
                    failures++;
                    $display("FAIL latency got=%0d want=8", cyc - s);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Drive A then B (nvld = number of consecutive valid cycles) and check the busy profile
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int nvld,
                          input logic [31:0] expv);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = a;
        if (nvld >= 2) begin
            exp_q.push_back(expv);
            st_q.push_back(cyc);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", k), {31'd0, busy},
                {31'd0, (nvld >= 2) && (k >= 1) && (k <= 8)});
            @(posedge clk); #1;
            if (k + 1 < nvld) begin
                in_valid = 1'b1;
                in_data  = (k == 0) ? b : 32'hDEAD_BEEF;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] tie_exp, ovf_exp;
        int dc;
`ifdef FP_ADD_ROUND_NEAREST_EN
        tie_exp = 32'h3F80_0002;
        ovf_exp = 32'h7F80_0000;
`else
        tie_exp = 32'h3F80_0001;
        ovf_exp = 32'h7F7F_FFFF;
`endif
        #12;
        chk("reset_res", res, 32'h0);
        chk("reset_done", {31'd0, done}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(32'h3F80_0000, 32'h4000_0000, 2, 32'h4040_0000);  // 1 + 2
        run_op(32'h3FC0_0000, 32'hBFC0_0000, 2, 32'h0000_0000);  // exact cancel
        run_op(32'h7F80_0000, 32'hFF80_0000, 2, 32'h7FC0_0000);  // +inf + -inf
        run_op(32'h3F80_0001, 32'h3380_0000, 2, tie_exp);        // tie
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 2, ovf_exp);        // overflow
        run_op(32'h7FC0_0001, 32'h3F80_0000, 2, 32'h7FC0_0000);  // NaN
        run_op(32'h8000_0000, 32'h8000_0000, 2, 32'h8000_0000);  // -0 + -0
        run_op(32'hFF80_0000, 32'h3F80_0000, 2, 32'hFF80_0000);  // -inf + 1
        run_op(32'h3F80_0000, 32'hBF40_0000, 2, 32'h3E80_0000);  // 1 - 0.75
        run_op(32'h4040_0000, 32'hBF80_0000, 2, 32'h4000_0000);  // 3 - 1
        run_op(32'h0000_0001, 32'h3F80_0000, 2, 32'h3F80_0000);  // denormal flushed
        run_op(32'h4000_0000, 32'h4040_0000, 3, 32'h40A0_0000);  // third valid ignored

        dc = done_cnt;
        run_op(32'h4120_0000, 32'h0, 1, 32'h0);                  // lone A discarded
        repeat (10) @(posedge clk);
        chk("lone_a_no_done", 32'(done_cnt), 32'(dc));
        run_op(32'h3F80_0000, 32'h3F80_0000, 2, 32'h4000_0000);

        // Reset in cycle 4 of an operation
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h3F80_0000;
        @(posedge clk); #1;
        in_data = 32'h4000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_res", res, 32'h0);
        chk("midrst_done", {31'd0, done}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        dc = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'(dc));
        run_op(32'h3F80_0000, 32'h4000_0000, 2, 32'h4040_0000);

        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_results got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_pair_adder.md
# fp_pair_adder

Sequential IEEE754 single-precision adder that consumes the two-word result burst produced by the dual-multiplier stage (word A on the first `in_valid` cycle, word B on the second) and returns A+B. It sits directly downstream of that stage so that two products can be summed, for example as a two-term dot product. It has a fixed-latency multi-cycle datapath and produces a one-cycle `done` pulse.

## Interface
Parameters: none.

Ports:
- `clk` input 1: clock; all registers update on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: high for two consecutive cycles; first cycle carries A, second carries B.
- `in_data` input 32: operand word, sampled while `in_valid`=1 and the block is not busy.
- `busy` output 1: high from the cycle after A is captured through the `done` cycle inclusive.
- `res` output 32: sum; holds its value until the next `done`.
- `done` output 1: one-cycle pulse; `res` is valid in this cycle.

## Operation
- FSM states: IDLE, CAPB, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: if `in_valid`=1, capture `in_data` as A and go to CAPB.
- CAPB: if `in_valid`=1, capture B and go to UNPACK. If `in_valid`=0, discard A, go to IDLE, and produce no `done`.
- UNPACK:
  - Split sign, exponent and mantissa, and add the hidden bit.
  - Flush denormal inputs (exp=0) to signed zero.
  - Detect specials.
  - Swap operands so that |A|≥|B|.
- ALIGN: right-shift B's mantissa by the exponent difference (a difference ≥26 means B reduces to sticky only). Keep the guard, round and sticky bits.
- ADD: add the mantissas if the signs are equal, otherwise subtract. Use a 28-bit datapath (carry, hidden bit, 23 fraction bits, G, R, S).
- NORM:
  - On carry-out, shift right by 1 (sticky-OR the dropped bit) and increment the exponent.
  - Otherwise left-shift by the leading-zero count and decrement the exponent.
  - This is done in a single cycle with a priority encoder.
- ROUND:
  - Apply the rounding mode (see Configuration).
  - If rounding causes a mantissa carry, renormalise.
  - If the exponent reaches ≥255, the result overflows.
  - If the exponent reaches ≤0, flush to signed zero.
- DONE: register `res`, pulse `done`, and return to IDLE.
- Special results:
  - Any NaN input gives 0x7FC00000.
  - +Inf + −Inf gives 0x7FC00000.
  - Inf + finite gives that Inf.
  - Exact cancellation (x + −x) gives 0x00000000.
  - −0 + −0 gives 0x80000000.
  - Specials bypass ALIGN through ROUND but still exit through DONE with the same latency.
- `in_valid` while `busy`=1 is ignored. A third or later consecutive `in_valid` cycle is ignored.

## Timing
- Cycle 0: `in_valid`=1, A is sampled.
- Cycle 1: B is sampled and `busy` rises.
- Cycle 8: `done`=1 and `res` is valid.
- Cycle 9: `busy`=0 and the block is in IDLE; a new A can be accepted in cycle 9.
- Latency is 8 cycles from A to `done`, fixed for every operand class.
- Reset: STATE=IDLE, `res`=0x00000000, `done`=0, `busy`=0, and all internal registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No `done` follows after reset is released.
- Matches the upstream burst exactly: upstream `done` high for 2 cycles with res1 then res2 maps directly onto `in_valid`/`in_data`.

## Configuration
- Macro `FP_ADD_ROUND_NEAREST_EN` defined:
  - Round to nearest, ties to even, using G/R/S.
  - Overflow gives ±Inf (0x7F800000 / 0xFF800000).
- Macro not defined:
  - Round toward zero (truncate, G/R/S dropped).
  - Overflow gives ±max finite (0x7F7FFFFF / 0xFF7FFFFF).
- Latency and the handshake are identical in both builds.

## Test plan
- 0x3F800000 then 0x40000000 (1.0+2.0): `done` in cycle 8 with `res`=0x40400000; `busy` high in cycles 1–8.
- 0x3FC00000 then 0xBFC00000 (1.5 + −1.5): `res`=0x00000000. Also 0x7F800000 then 0xFF800000: `res`=0x7FC00000.
- 0x3F800001 then 0x33800000 (a tie):
  - With the macro: `res`=0x3F800002.
  - Without the macro: `res`=0x3F800001.
- 0x7F7FFFFF then 0x7F7FFFFF:
  - With the macro: `res`=0x7F800000.
  - Without the macro: `res`=0x7F7FFFFF.
- `in_valid` high for cycle 0 only: no `done` within 20 cycles, and `busy` stays 0. A following valid two-cycle pair completes normally.
- `rst` pulsed in cycle 4 of an operation: `res`=0, `done`=0 and `busy`=0 immediately, no later `done`, and the next pair completes with the correct sum.
